uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 72 +++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults and pointer-width helper for the UART RX FIFO
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // Address bits plus one wrap bit, so full and empty can be told apart
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - generic show-ahead push/pop FIFO; level output under UART_RX_FIFO_LEVEL_EN
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        empty,
  output logic                        full
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] level
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A push while full is taken only when the head leaves in the same cycle;
  // clear wins over both
  assign wr_en = push & (~full | pop) & ~clr;
  assign rd_en = pop & ~empty & ~clr;

  assign pop_data = mem[rptr[AW-1:0]];

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level = wptr - rptr;
`endif

  // Storage array: write at the tail, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with edge-detected push and sticky overflow; Level port under UART_RX_FIFO_LEVEL_EN
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        RX_Done,
  input  logic [WIDTH-1:0]            RX_Bytes,
  input  logic                        Clear,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [WIDTH-1:0]            Out_Data,
  output logic                        Full,
  output logic                        Overflow
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] Level
`endif
);

  logic rx_done_q;
  logic push_ev;
  logic pop_ev;
  logic fifo_empty;

  assign push_ev   = RX_Done & ~rx_done_q;
  assign Out_Valid = ~fifo_empty;
  assign pop_ev    = Out_Valid & Out_Ready;

  // Previous RX_Done level; resets high so a level already high at release is not an edge
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_done_q <= 1'b1;
    end else begin
      rx_done_q <= RX_Done;
    end
  end

  // Sticky overflow: a byte arrived with no room and no departing head
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Overflow <= 1'b0;
    end else if (Clear) begin
      Overflow <= 1'b0;
    end else if (push_ev & Full & ~pop_ev) begin
      Overflow <= 1'b1;
    end
  end

  uart_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .clr       (Clear),
    .push      (push_ev),
    .push_data (RX_Bytes),
    .pop       (pop_ev),
    .pop_data  (Out_Data),
    .empty     (fifo_empty),
    .full      (Full)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level     (Level)
`endif
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             Clock;
  logic             Reset_n;
  logic             RX_Done;
  logic [WIDTH-1:0] RX_Bytes;
  logic             Clear;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic             Full;
  logic             Overflow;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [LW-1:0]    Level;
`endif

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .RX_Done   (RX_Done),
    .RX_Bytes  (RX_Bytes),
    .Clear     (Clear),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Full      (Full),
    .Overflow  (Overflow)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .Level     (Level)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf;
  logic             prev_done;
  logic [WIDTH-1:0] drained[$];
  int               drain_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":valid"}, 32'(Out_Valid), 32'(model_q.size() != 0));
    chk({tag, ":full"}, 32'(Full), 32'(model_q.size() == DEPTH));
    chk({tag, ":ovf"}, 32'(Overflow), 32'(model_ovf));
    if (model_q.size() != 0) chk({tag, ":data"}, 32'(Out_Data), 32'(model_q[0]));
`ifdef UART_RX_FIFO_LEVEL_EN
    chk({tag, ":level"}, 32'(Level), 32'(model_q.size()));
`endif
  endtask

  // One clock: model the effect of the inputs present at the edge, then compare
  task automatic step(input string tag);
    int               n;
    bit               pu, po, fl;
    logic [WIDTH-1:0] d;
    n  = model_q.size();
    pu = RX_Done && !prev_done;
    po = (n != 0) && Out_Ready;
    fl = (n == DEPTH);
    @(posedge Clock);
    #1;
    if (Clear) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (po) d = model_q.pop_front();
      if (pu) begin
        if (!fl || po) model_q.push_back(RX_Bytes);
        else model_ovf = 1'b1;
      end
    end
    prev_done = RX_Done;
    check_state(tag);
  endtask

  task automatic push_byte(input logic [WIDTH-1:0] b);
    RX_Bytes = b;
    RX_Done  = 1'b1;
    step("push_hi");
    RX_Done  = 1'b0;
    step("push_lo");
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    model_q.delete();
    model_ovf = 1'b0;
    prev_done = 1'b1;
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("rst_level", 32'(Level), 32'd0);
`endif
    @(posedge Clock);
    #1;
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic drain();
    drained.delete();
    drain_cycles = 0;
    Out_Ready = 1'b1;
    while (Out_Valid && drain_cycles < 40) begin
      drained.push_back(Out_Data);
      step("drain");
      drain_cycles++;
    end
    Out_Ready = 1'b0;
    chk("drain_bound", 32'(drain_cycles < 40), 32'd1);
  endtask

  initial begin
    Reset_n   = 1'b1;
    RX_Done   = 1'b1;
    RX_Bytes  = '0;
    Clear     = 1'b0;
    Out_Ready = 1'b0;
    model_ovf = 1'b0;
    prev_done = 1'b1;

    // RX_Done held high through reset release and for 10 more cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step("hold_hi");
      chk("hold_hi_novalid", 32'(Out_Valid), 32'd0);
    end
    RX_Done = 1'b0;
    step("hold_lo");

    // Three bytes queued, then drained in order one per cycle
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    drain();
    chk("abc_count", 32'(drained.size()), 32'd3);
    chk("abc_cycles", 32'(drain_cycles), 32'd3);
    if (drained.size() == 3) begin
      chk("abc_0", 32'(drained[0]), 32'h41);
      chk("abc_1", 32'(drained[1]), 32'h42);
      chk("abc_2", 32'(drained[2]), 32'h43);
    end
    chk("abc_empty", 32'(Out_Valid), 32'd0);

    // Fill to full, then one extra byte overflows
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i));
      if (i == 14) chk("fill_not_full", 32'(Full), 32'd0);
      if (i == 15) chk("fill_full", 32'(Full), 32'd1);
      if (i == 15) chk("fill_no_ovf", 32'(Overflow), 32'd0);
      if (i == 16) chk("fill_ovf", 32'(Overflow), 32'd1);
    end
    drain();
    chk("ovf_drain_count", 32'(drained.size()), 32'd16);
    for (int i = 0; i < drained.size(); i++) chk("ovf_drain_data", 32'(drained[i]), 32'(i));
    chk("ovf_sticky", 32'(Overflow), 32'd1);

    Clear = 1'b1;
    step("clear");
    Clear = 1'b0;
    chk("clear_ovf", 32'(Overflow), 32'd0);

    // Push coinciding with pop while full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    chk("pp_full_before", 32'(Full), 32'd1);
    RX_Bytes  = 8'hAA;
    RX_Done   = 1'b1;
    Out_Ready = 1'b1;
    step("pp_edge");
    RX_Done   = 1'b0;
    Out_Ready = 1'b0;
    step("pp_after");
    chk("pp_ovf", 32'(Overflow), 32'd0);
    chk("pp_full", 32'(Full), 32'd1);
    drain();
    chk("pp_count", 32'(drained.size()), 32'd16);
    if (drained.size() == 16) begin
      chk("pp_first", 32'(drained[0]), 32'h21);
      chk("pp_last", 32'(drained[15]), 32'hAA);
    end

    // Clear in the same cycle as a push edge, with 5 bytes stored and Overflow set
    for (int i = 0; i < 17; i++) push_byte(8'(8'h50 + i));
    Out_Ready = 1'b1;
    for (int i = 0; i < 11; i++) step("pre_clr_pop");
    Out_Ready = 1'b0;
    chk("pre_clr_count", 32'(model_q.size()), 32'd5);
    chk("pre_clr_valid", 32'(Out_Valid), 32'd1);
    chk("pre_clr_ovf", 32'(Overflow), 32'd1);
    RX_Bytes = 8'h99;
    RX_Done  = 1'b1;
    Clear    = 1'b1;
    step("clr_push");
    chk("clr_valid", 32'(Out_Valid), 32'd0);
    chk("clr_ovf", 32'(Overflow), 32'd0);
    Clear   = 1'b0;
    RX_Done = 1'b0;
    step("clr_after");
    chk("clr_absent", 32'(Out_Valid), 32'd0);
    push_byte(8'h77);
    chk("post_clr_data", 32'(Out_Data), 32'h77);

    // Reset mid-operation discards stored bytes
    push_byte(8'h12);
    do_reset();
    step("post_rst");
    chk("mid_rst_valid", 32'(Out_Valid), 32'd0);

    // Random traffic, long enough for the pointers to wrap several times
    for (int i = 0; i < 400; i++) begin
      RX_Done   = 1'($urandom_range(0, 1));
      RX_Bytes  = 8'($urandom);
      Out_Ready = ($urandom_range(0, 9) < 4);
      step("rand");
    end
    Out_Ready = 1'b1;
    RX_Done   = 1'b0;
    for (int i = 0; i < 20; i++) step("rand_drain");
    chk("rand_empty", 32'(Out_Valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
